// File: rtl/pixel_shift_reg_pkg.sv
// Shared WS2812 receive-pipeline constants and stage bundle types.
// Pixel stage types sit beside the bit decoder output bundle.
package timing_constants;
  localparam int BITS_PER_PIXEL_DEFAULT = 24;
endpackage

package pipeline_types;
  typedef struct packed {
    logic decode_bit;
    logic shift_en;
    logic treset;
  } shift_reg_input_t;

  typedef struct packed {
    logic [23:0] grb;
    logic        valid;
  } pixel_output_t;

  // "bit" is a keyword, so the forwarded value is carried in "data".
  typedef struct packed {
    logic data;
    logic valid;
  } forward_output_t;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    FORWARD,
    LATCHED
  } pixel_state_e;
endpackage

// File: rtl/pixel_shift_reg_treset_edge.sv
// Registers the latch level and strobes its rising and falling edges.
// Shared with the retransmit stage.
module treset_edge (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic level,
  output logic rise,
  output logic fall
);

  logic treset_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) treset_q <= 1'b0;
    else            treset_q <= level;
  end

  assign rise = level & ~treset_q;
  assign fall = ~level & treset_q;

endmodule

// File: rtl/pixel_shift_reg.sv
// Claims the first GRB pixel of each frame and forwards the rest.
// Presents the pixel on the latch edge; flags mid-pixel latches.
module pixel_shift_reg
  import pipeline_types::*;
  import timing_constants::*;
#(
  parameter int BITS_PER_PIXEL = BITS_PER_PIXEL_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  shift_reg_input_t i_shift_reg,
  output pixel_output_t    o_pixel,
  output forward_output_t  o_forward,
  output logic             o_frame_error,
  output logic [15:0]      o_forward_count
);

  localparam int CW = $clog2(BITS_PER_PIXEL + 1);
  localparam int BP = BITS_PER_PIXEL;

  pixel_state_e  state, state_nx;
  logic [BP-1:0] shreg, shreg_nx;
  logic [23:0]   pending;
  logic [CW-1:0] bit_cnt;

  logic rise, fall, sh;
  logic do_shift, do_done, do_fwd;
  logic do_latch, do_err, do_clr;

  treset_edge u_edge (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .level     (i_shift_reg.treset),
    .rise      (rise),
    .fall      (fall)
  );

  // Strobes during the latch period never reach the datapath.
  assign sh = i_shift_reg.shift_en & ~i_shift_reg.treset;
  assign shreg_nx = (shreg << 1) | BP'(i_shift_reg.decode_bit);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    do_shift = 1'b0;
    do_done  = 1'b0;
    do_fwd   = 1'b0;
    do_latch = 1'b0;
    do_err   = 1'b0;
    do_clr   = 1'b0;
    if (rise) begin
      state_nx = LATCHED;
      do_clr   = 1'b1;
      do_latch = (state == FORWARD);
      do_err   = (state == CAPTURE);
    end else begin
      unique case (state)
        IDLE: if (sh) begin
          do_shift = 1'b1;
          if (BP == 1) begin
            do_done  = 1'b1;
            state_nx = FORWARD;
          end else begin
            state_nx = CAPTURE;
          end
        end
        CAPTURE: if (sh) begin
          do_shift = 1'b1;
          if (bit_cnt == CW'(BP - 1)) begin
            do_done  = 1'b1;
            state_nx = FORWARD;
          end
        end
        FORWARD: do_fwd = sh;
        LATCHED: if (fall) state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      shreg           <= '0;
      pending         <= '0;
      bit_cnt         <= '0;
      o_forward_count <= '0;
    end else if (do_clr) begin
      shreg           <= '0;
      bit_cnt         <= '0;
      o_forward_count <= '0;
    end else begin
      if (do_shift) begin
        shreg   <= shreg_nx;
        bit_cnt <= bit_cnt + CW'(1);
      end
      if (do_done) pending <= 24'(shreg_nx);
      if (do_fwd && o_forward_count != 16'hFFFF)
        o_forward_count <= o_forward_count + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_pixel       <= '0;
      o_forward     <= '0;
      o_frame_error <= 1'b0;
    end else begin
      o_pixel.valid   <= do_latch;
      o_forward.valid <= do_fwd;
      o_frame_error   <= do_err;
      if (do_latch) o_pixel.grb    <= pending;
      if (do_fwd)   o_forward.data <= i_shift_reg.decode_bit;
    end
  end

endmodule

// File: tb/tb_pixel_shift_reg.sv
// Directed bench for pixel_shift_reg: capture, forward, latch,
// partial-frame error, ignored strobes and mid-frame reset.
module tb_pixel_shift_reg;
  import pipeline_types::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  shift_reg_input_t sin = '0;
  pixel_output_t    pix;
  forward_output_t  fwd;
  logic             ferr;
  logic [15:0]      fcnt;

  int total = 0;
  int bad = 0;

  int          n_fwd = 0;
  int          n_pix = 0;
  int          n_err = 0;
  logic [23:0] fwd_acc = '0;

  pixel_shift_reg dut (
    .i_clk           (clk),
    .i_reset_n       (rst_n),
    .i_shift_reg     (sin),
    .o_pixel         (pix),
    .o_forward       (fwd),
    .o_frame_error   (ferr),
    .o_forward_count (fcnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fwd.valid) begin
      n_fwd   <= n_fwd + 1;
      fwd_acc <= {fwd_acc[22:0], fwd.data};
    end
    if (pix.valid) n_pix <= n_pix + 1;
    if (ferr)      n_err <= n_err + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n,
                           input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      sin.shift_en   = 1'b1;
      sin.decode_bit = v[i];
      step();
      sin.shift_en = 1'b0;
      repeat (gap - 1) step();
    end
  endtask

  task automatic latch_chk(input string tag, input logic exp_v,
                           input logic exp_e, input logic [23:0] exp_grb);
    sin.treset = 1'b1;
    step();
    chk({tag, "_valid"}, 32'(pix.valid), 32'(exp_v));
    chk({tag, "_err"}, 32'(ferr), 32'(exp_e));
    chk({tag, "_grb"}, 32'(pix.grb), 32'(exp_grb));
    step();
    chk({tag, "_valid_off"}, 32'(pix.valid), 32'd0);
    chk({tag, "_err_off"}, 32'(ferr), 32'd0);
    chk({tag, "_cnt_clr"}, 32'(fcnt), 32'd0);
    sin.treset = 1'b0;
    step();
    step();
  endtask

  initial begin
    int b_fwd, b_pix, b_err;
    logic [29:0] v30;

    repeat (3) step();
    chk("rst_grb", 32'(pix.grb), 32'd0);
    chk("rst_pvalid", 32'(pix.valid), 32'd0);
    chk("rst_fwd", 32'(fwd), 32'd0);
    chk("rst_err", 32'(ferr), 32'd0);
    chk("rst_cnt", 32'(fcnt), 32'd0);
    rst_n = 1'b1;
    step();

    b_fwd = n_fwd;
    send_bits(32'hA5C33C, 24, 4);
    latch_chk("t1", 1'b1, 1'b0, 24'hA5C33C);
    chk("t1_no_fwd", 32'(n_fwd - b_fwd), 32'd0);

    b_fwd = n_fwd;
    send_bits(32'h112233, 24, 2);
    send_bits(32'hFFEE01, 24, 2);
    chk("t2_cnt", 32'(fcnt), 32'd24);
    latch_chk("t2", 1'b1, 1'b0, 24'h112233);
    chk("t2_nfwd", 32'(n_fwd - b_fwd), 32'd24);
    chk("t2_fwd_bits", 32'(fwd_acc), 32'hFFEE01);

    b_pix = n_pix;
    b_err = n_err;
    send_bits(32'h2AA, 10, 1);
    latch_chk("t3", 1'b0, 1'b1, 24'h112233);
    chk("t3_npix", 32'(n_pix - b_pix), 32'd0);
    chk("t3_nerr", 32'(n_err - b_err), 32'd1);

    b_fwd = n_fwd;
    b_err = n_err;
    send_bits(32'h0F0F0F, 24, 1);
    sin.treset     = 1'b1;
    sin.shift_en   = 1'b1;
    sin.decode_bit = 1'b1;
    step();
    sin.shift_en = 1'b0;
    chk("t4_valid", 32'(pix.valid), 32'd1);
    chk("t4_grb", 32'(pix.grb), 32'h0F0F0F);
    for (int i = 0; i < 5; i++) begin
      sin.shift_en = 1'b1;
      step();
      sin.shift_en = 1'b0;
      step();
    end
    chk("t4_hold_cnt", 32'(fcnt), 32'd0);
    chk("t4_hold_fwd", 32'(n_fwd - b_fwd), 32'd0);
    chk("t4_hold_err", 32'(n_err - b_err), 32'd0);
    chk("t4_hold_grb", 32'(pix.grb), 32'h0F0F0F);
    sin.treset = 1'b0;
    step();
    step();
    send_bits(32'h123456, 24, 1);
    latch_chk("t4b", 1'b1, 1'b0, 24'h123456);

    b_err = n_err;
    send_bits(32'hABC, 12, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_grb", 32'(pix.grb), 32'd0);
    chk("t5_rst_cnt", 32'(fcnt), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    send_bits(32'h00FF00, 24, 1);
    latch_chk("t5", 1'b1, 1'b0, 24'h00FF00);
    chk("t5_nerr", 32'(n_err - b_err), 32'd0);

    v30 = {24'hC0FFEE, 6'b101101};
    for (int k = 0; k <= 30; k++) begin
      if (k >= 1) begin
        chk($sformatf("t6_fv%0d", k), 32'(fwd.valid),
            32'(k >= 25));
        if (k >= 25)
          chk($sformatf("t6_fd%0d", k), 32'(fwd.data),
              32'(v30[30 - k]));
      end
      if (k < 30) begin
        sin.shift_en   = 1'b1;
        sin.decode_bit = v30[29 - k];
      end else begin
        sin.shift_en = 1'b0;
      end
      step();
    end
    chk("t6_cnt", 32'(fcnt), 32'd6);
    latch_chk("t6", 1'b1, 1'b0, 24'hC0FFEE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
